demux_1_4_reg: RTL

Registered 1-to-4 demultiplexer: the inverse of the 4:1 mux. It accepts one DATA_WIDTH word per cycle with a 2-bit key and steers it into one of four output lanes. Each lane has a one-entry output register with a valid/ready handshake, so downstream consumers can stall independently. It sits between a single producer and four consumers, for example a decode stage feeding four functional-unit queues.

---
 rtl/demux_1_4_reg.sv | 77 +++++++
 1 files changed

// File: rtl/demux_1_4_reg.sv
// Registered 1-to-4 demultiplexer with a one-entry valid/ready register per lane.
// Optional per-lane drain counters are enabled with `define DEMUX_1_4_REG_CNT_EN.
module demux_1_4_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [1:0]                 i_key,
  input  logic [DATA_WIDTH-1:0]      i_val,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [3:0][DATA_WIDTH-1:0] o_val,
  output logic [3:0]                 o_valid,
  input  logic [3:0]                 i_ready
`ifdef DEMUX_1_4_REG_CNT_EN
  ,
  output logic [3:0][CNT_WIDTH-1:0]  o_cnt
`endif
);

  if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("demux_1_4_reg: DATA_WIDTH and CNT_WIDTH must be at least 1");
  end

  logic [3:0][DATA_WIDTH-1:0] val_q, val_d;
  logic [3:0]                 valid_q, valid_d;
  logic [3:0]                 drain;
  logic                       accept;

  always_comb begin
    drain   = valid_q & i_ready;
    o_ready = !valid_q[i_key] || i_ready[i_key];
    accept  = i_valid && o_ready;
    val_d   = val_q;
    valid_d = valid_q & ~drain;
    for (int unsigned k = 0; k < 4; k++) begin
      if (accept && (i_key == 2'(k))) begin
        val_d[k]   = i_val;
        valid_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      val_q   <= '0;
      valid_q <= '0;
    end else begin
      val_q   <= val_d;
      valid_q <= valid_d;
    end
  end

  assign o_val   = val_q;
  assign o_valid = valid_q;

`ifdef DEMUX_1_4_REG_CNT_EN
  logic [3:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Counts completed drains; wraps naturally at 2^CNT_WIDTH.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (drain[k]) cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;
`endif

endmodule
